// File: rtl/data_memory_bytelane.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_bytelane
// Purpose  : Byte-lane data memory for the RV32I MEM stage. Executes
//            LB/LH/LW/LBU/LHU/SB/SH/SW against a word-organised array with
//            byte enables, sign/zero extension and registered read data.
//            Misaligned, out-of-range and illegal accesses are rejected with
//            a one-cycle fault pulse. After reset a sweep zeroes every word
//            and holds ready low until it completes.
// Ports    : clk, rst (async, active-high)
//            req_rd, req_wr, funct3, addr, wdata  - request side
//            ready                                - accepting requests
//            rdata, rvalid, fault                 - registered response
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_bytelane #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_rd,
    input  logic            req_wr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            ready,
    output logic [XLEN-1:0] rdata,
    output logic            rvalid,
    output logic            fault
);

    localparam logic [0:0]    S_CLEAR   = 1'b0;
    localparam logic [0:0]    S_RUN     = 1'b1;
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    logic [0:0]    r_state;
    logic [0:0]    w_state_next;
    logic [AW-1:0] r_clr_cnt;
    logic          w_clr_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_cnt == LAST_WORD) w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_CLEAR;
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        w_clr_we = 1'b0;
        case (r_state)
            S_CLEAR: w_clr_we = 1'b1;
            S_RUN:   ready    = 1'b1;
            default: w_clr_we = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [AW-1:0]   w_idx;
    logic [1:0]      w_lane;
    logic            w_accept;
    logic            w_bad;
    logic            w_fault;
    logic            w_load_ok;
    logic            w_store_ok;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata_rep;

    assign w_idx    = addr[AW+1:2];
    assign w_lane   = addr[1:0];
    assign w_accept = ready && (req_rd || req_wr);

    always_comb begin
        w_bad = 1'b0;
        if (req_rd && req_wr) begin
            w_bad = 1'b1;
        end
        if (req_rd && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)) begin
            w_bad = 1'b1;
        end
        // Stores only have the unsigned-free encodings 000/001/010.
        if (req_wr && (funct3[2] || funct3[1:0] == 2'b11)) begin
            w_bad = 1'b1;
        end
        if (funct3[1:0] == 2'b01 && addr[0]) begin
            w_bad = 1'b1;
        end
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) begin
            w_bad = 1'b1;
        end
        // Any address bit above the array span means out of range.
        if (|addr[XLEN-1:AW+2]) begin
            w_bad = 1'b1;
        end
    end

    assign w_fault    = w_accept && w_bad;
    assign w_load_ok  = w_accept && !w_bad && req_rd;
    assign w_store_ok = w_accept && !w_bad && req_wr;

    // Store data is replicated across lanes so each enabled lane simply
    // takes its own byte slice of the replicated word.
    always_comb begin
        w_be        = 4'b0000;
        w_wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_be[w_lane] = 1'b1;
                w_wdata_rep  = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be        = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{wdata[15:0]}};
            end
            2'b10: begin
                w_be        = 4'b1111;
                w_wdata_rep = wdata;
            end
            default: begin
                w_be        = 4'b0000;
                w_wdata_rep = wdata;
            end
        endcase
    end

    // The array has no reset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            mem[r_clr_cnt] <= '0;
        end else if (w_store_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    mem[w_idx][8*k +: 8] <= w_wdata_rep[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline: the word is captured at the acceptance edge and
    // the extended result is registered one edge later.
    // ------------------------------------------------------------------
    logic            r_p_load;
    logic            r_p_fault;
    logic [2:0]      r_p_f3;
    logic [1:0]      r_p_lane;
    logic [XLEN-1:0] r_p_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_load  <= 1'b0;
            r_p_fault <= 1'b0;
            r_p_f3    <= 3'b000;
            r_p_lane  <= 2'b00;
            r_p_word  <= '0;
        end else begin
            r_p_load  <= w_load_ok;
            r_p_fault <= w_fault;
            if (w_load_ok) begin
                r_p_f3   <= funct3;
                r_p_lane <= w_lane;
                r_p_word <= mem[w_idx];
            end
        end
    end

    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_ext;

    assign w_byte = r_p_word[8*r_p_lane +: 8];
    assign w_half = r_p_lane[1] ? r_p_word[31:16] : r_p_word[15:0];

    always_comb begin
        w_ext = r_p_word;
        case (r_p_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = r_p_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            fault  <= 1'b0;
        end else begin
            rvalid <= r_p_load;
            fault  <= r_p_fault;
            if (r_p_fault) begin
                rdata <= '0;
            end else if (r_p_load) begin
                rdata <= w_ext;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_bytelane.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_bytelane
// Purpose  : Self-checking bench for data_memory_bytelane. Directed steps
//            followed by random traffic, compared against a byte-addressed
//            reference model of RV32I load/store behaviour.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_bytelane;

    localparam int DEPTH = 64;
    localparam int BYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd;
    logic        req_wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        fault;

    always #5 clk = ~clk;

    data_memory_bytelane #(.XLEN(32), .DEPTH_WORDS(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req_rd (req_rd),
        .req_wr (req_wr),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .ready  (ready),
        .rdata  (rdata),
        .rvalid (rvalid),
        .fault  (fault)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  mb [BYTES];
    logic [31:0] exp_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_fault(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = acc_size(f3);
        if (rd && wr) return 1'b1;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        if ((a % sz) != 0) return 1'b1;
        if (a >= BYTES) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        longint unsigned v;
        int sz;
        sz = acc_size(f3);
        v  = 0;
        for (int i = 0; i < sz; i++) v |= longint'(mb[a + i]) << (8 * i);
        if (!f3[2] && sz < 4 && (((v >> (8 * sz - 1)) & 1) == 1))
            v |= ~((64'd1 << (8 * sz)) - 1);
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] s;
        s = wd;
        for (int i = 0; i < acc_size(f3); i++) begin
            mb[a + i] = s[7:0];
            s = s >> 8;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;
        exp_rdata = 32'h0;
    endtask

    // One isolated request: accepted at edge N, response checked after N+1.
    task automatic op(input string tag, input logic rd, input logic wr,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bit          flt;
        logic [31:0] ev;
        flt = model_fault(rd, wr, f3, a);
        ev  = flt ? 32'h0 : model_load(f3, a);
        req_rd = rd; req_wr = wr; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        req_rd = 1'b0; req_wr = 1'b0;
        check({tag, "/early_rvalid"}, {31'd0, rvalid}, 32'd0);
        check({tag, "/early_fault"},  {31'd0, fault},  32'd0);
        @(posedge clk); #1;
        if (flt) exp_rdata = 32'h0;
        else if (rd) exp_rdata = ev;
        if (wr && !flt) model_store(f3, a, wd);
        check({tag, "/rvalid"}, {31'd0, rvalid}, {31'd0, rd && !flt});
        check({tag, "/fault"},  {31'd0, fault},  {31'd0, flt});
        check({tag, "/rdata"},  rdata, exp_rdata);
    endtask

    // Reset and count the sweep while a load is held pending.
    task automatic do_reset();
        rst = 1'b1;
        req_rd = 1'b0; req_wr = 1'b0; funct3 = 3'b010; addr = 32'h0; wdata = 32'h0;
        #12;
        check("rst/ready",  {31'd0, ready},  32'd0);
        check("rst/rvalid", {31'd0, rvalid}, 32'd0);
        check("rst/fault",  {31'd0, fault},  32'd0);
        check("rst/rdata",  rdata,           32'd0);
        @(negedge clk);
        rst    = 1'b0;
        req_rd = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk); #1;
            if (i < DEPTH) check($sformatf("sweep/ready@%0d", i), {31'd0, ready}, 32'd0);
            else           check("sweep/ready_up", {31'd0, ready}, 32'd1);
            check($sformatf("sweep/rvalid@%0d", i), {31'd0, rvalid}, 32'd0);
        end
        req_rd = 1'b0;
        model_clear();
    endtask

    initial begin
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;

        do_reset();
        op("lw0", 1, 0, 3'b010, 32'h0, 32'h0);

        op("sw10",  0, 1, 3'b010, 32'h10, 32'h8000_80F1);
        op("lb10",  1, 0, 3'b000, 32'h10, 32'h0);
        check("lb10/value", rdata, 32'hFFFF_FFF1);
        op("lbu10", 1, 0, 3'b100, 32'h10, 32'h0);
        check("lbu10/value", rdata, 32'h0000_00F1);
        op("lh10",  1, 0, 3'b001, 32'h10, 32'h0);
        check("lh10/value", rdata, 32'hFFFF_80F1);
        op("lhu10", 1, 0, 3'b101, 32'h10, 32'h0);
        check("lhu10/value", rdata, 32'h0000_80F1);
        op("lh12",  1, 0, 3'b001, 32'h12, 32'h0);
        check("lh12/value", rdata, 32'hFFFF_8000);

        op("sw20", 0, 1, 3'b010, 32'h20, 32'h0);
        op("sb23", 0, 1, 3'b000, 32'h23, 32'hFFFF_FFAB);
        op("sh20", 0, 1, 3'b001, 32'h20, 32'hFFFF_1234);
        op("lw20", 1, 0, 3'b010, 32'h20, 32'h0);
        check("lw20/value", rdata, 32'hAB00_1234);

        op("sw04",    0, 1, 3'b010, 32'h04,  32'hCAFE_0004);
        op("lw02",    1, 0, 3'b010, 32'h02,  32'h0);
        op("sh05",    0, 1, 3'b001, 32'h05,  32'hDEAD_BEEF);
        op("lw100",   1, 0, 3'b010, 32'h100, 32'h0);
        op("both04",  1, 1, 3'b010, 32'h04,  32'h1111_1111);
        op("f3_011",  1, 0, 3'b011, 32'h08,  32'h0);
        op("lw04",    1, 0, 3'b010, 32'h04,  32'h0);
        check("lw04/unchanged", rdata, 32'hCAFE_0004);

        // Back-to-back store then load to the same word.
        req_rd = 0; req_wr = 1; funct3 = 3'b010; addr = 32'h30; wdata = 32'h5A5A_1234;
        @(posedge clk); #1;
        req_rd = 1; req_wr = 0;
        @(posedge clk); #1;
        req_rd = 0;
        check("b2b/store_no_rvalid", {31'd0, rvalid}, 32'd0);
        @(posedge clk); #1;
        model_store(3'b010, 32'h30, 32'h5A5A_1234);
        exp_rdata = model_load(3'b010, 32'h30);
        check("b2b/rvalid", {31'd0, rvalid}, 32'd1);
        check("b2b/rdata",  rdata, exp_rdata);

        // Random traffic against the model.
        for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 9);
            rd = (r < 5) || (r == 9);
            wr = (r >= 5);
            f3 = ($urandom_range(0, 9) < 8) ? (wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'b100 : 3'b000))
                                            : 3'($urandom_range(0, 7));
            if (f3 == 3'b110) f3 = 3'b100;
            a = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(BYTES, BYTES + 64)) : 32'($urandom_range(0, BYTES - 1));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_size(f3) - 1);
            op($sformatf("rnd%0d", n), rd, wr, f3, a, $urandom);
        end

        // Reset while a load is in flight.
        op("sw00", 0, 1, 3'b010, 32'h0, 32'h0000_0055);
        req_rd = 1; req_wr = 0; funct3 = 3'b010; addr = 32'h0;
        @(posedge clk); #1;
        req_rd = 0;
        rst = 1'b1;
        #1;
        check("midrst/ready",  {31'd0, ready},  32'd0);
        check("midrst/rvalid", {31'd0, rvalid}, 32'd0);
        @(posedge clk); #1;
        check("midrst/rvalid_held", {31'd0, rvalid}, 32'd0);
        do_reset();
        op("lw0_after", 1, 0, 3'b010, 32'h0, 32'h0);
        check("lw0_after/value", rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory_bytelane.md
# data_memory_bytelane

Parametrised byte-lane data memory for the MEM stage of the 5-stage RISC-V pipeline. It executes the full RV32I load/store set (LB/LH/LW/LBU/LHU/SB/SH/SW) against a word-organised array with byte enables, sign/zero extension and registered read data. It detects misaligned, out-of-range and illegal accesses, and clears itself with a sweep FSM after reset, holding `ready` low until the sweep completes.

## Interface

**Parameters**
- `XLEN`, default 32. Data and address width. Fixed at 32 for RV32I.
- `DEPTH_WORDS`, default 64. Number of 32-bit words. Must be a power of two and at least 2.
- `AW`, default `$clog2(DEPTH_WORDS)`. Word-index width. Derived; not overridden.

**Ports**
- `clk`, input, 1. Clock.
- `rst`, input, 1. Reset: asynchronous, active-high.
- `req_rd`, input, 1. Load request, sampled when `ready`=1.
- `req_wr`, input, 1. Store request, sampled when `ready`=1.
- `funct3`, input, 3. RISC-V funct3 of the memory instruction.
- `addr`, input, XLEN. Byte address (ALU result).
- `wdata`, input, XLEN. Store data (rs2). Low bytes are used for SB/SH.
- `ready`, output, 1. High when the block accepts requests.
- `rdata`, output, XLEN. Extended load data, registered.
- `rvalid`, output, 1. One-cycle pulse when `rdata` holds a completed load.
- `fault`, output, 1. One-cycle pulse on a rejected access.

## Operation

**Index and lane**
- Word index is `addr[AW+1:2]`. Byte lane is `addr[1:0]`.

**Store byte enables**
- SB (funct3=000): enables lane `addr[1:0]`. Writes `wdata[7:0]` into that lane.
- SH (001): enables lanes `{addr[1],0}` and `{addr[1],1}`. Writes `wdata[15:0]`.
- SW (010): enables all 4 lanes. Writes `wdata`.
- Memory is little-endian: byte lane k maps to word bits [8k+7:8k].

**Load extraction**
- LB/LBU (000/100): select the byte at the lane. LB sign-extends bit 7; LBU zero-extends.
- LH/LHU (001/101): select the halfword. LH sign-extends bit 15; LHU zero-extends.
- LW (010): the full word.

**Fault conditions**
Any one of these is a fault. On a fault: no array write, `rdata` is 0, `fault` pulses, and `rvalid` stays low.
- `req_rd` and `req_wr` both high.
- funct3 is 011, 110 or 111. For stores, any funct3 other than 000/001/010.
- Halfword access with `addr[0]`=1.
- Word access with `addr[1:0]`≠0.
- `addr` ≥ 4·DEPTH_WORDS.

**Handshake**
- Requests arriving while `ready`=0 are ignored: no response and no write.
- A store completes silently; `rvalid` is not raised for stores.

**FSM**
- CLEAR: writes 0 to word `clr_cnt` each cycle; `clr_cnt` increments each cycle; `ready`=0.
  - When `clr_cnt`=DEPTH_WORDS−1, the next state is RUN.
- RUN: `ready`=1. Services requests. Stays in RUN until `rst`.
- `rst` from any state forces CLEAR with `clr_cnt`=0.

## Timing

**Reset values**
- `ready`=0, `rdata`=0, `rvalid`=0, `fault`=0, state=CLEAR, `clr_cnt`=0.
- Array contents are undefined until the sweep finishes.

**Clear sweep**
- After `rst` deasserts, the sweep takes DEPTH_WORDS cycles.
- `ready` rises at the DEPTH_WORDS-th rising edge after deassertion. With the default, that is edge 64.

**Load**
- Accepted at edge N. `rdata` and `rvalid` are valid after edge N+1, i.e. one cycle of latency.
- `rdata` holds its value until the next accepted load or fault.

**Store**
- The array is written at the acceptance edge.
- A load accepted at the next edge to the same word returns the new data.
- Back-to-back stores and loads are accepted every cycle with no bubbles.

**Fault**
- `fault` is registered and pulses at the same cycle position as `rvalid` would.

**Reset mid-operation**
- An in-flight `rvalid` or `fault` is cleared immediately.
- The sweep restarts from word 0.

## Test plan

- Reset, then hold `req_rd`=1 → `ready`=0 for exactly 64 cycles with no `rvalid`. After `ready` rises, LW at 0x0 → `rdata`=0x00000000.
- SW 0x8000_80F1 at 0x10, then LB / LBU / LH / LHU at 0x10 → 0xFFFFFFF1, 0x000000F1, 0xFFFF80F1, 0x000080F1. LH at 0x12 → 0xFFFF8000.
- SW 0 at 0x20, SB 0xAB at 0x23, SH 0x1234 at 0x20 → LW 0x20 = 0xAB001234.
- LW 0x02, SH 0x05, and LW 0x100 (DEPTH_WORDS=64) → each gives `fault`=1 and `rvalid`=0. A following LW 0x04 is unchanged.
- `req_rd`=`req_wr`=1, and funct3=011 load → `fault` pulse and no write.
- Assert `rst` during RUN after SW 0x55 at 0x0 → `ready`=0 at once and stays low for 64 cycles; LW 0x0 afterwards returns 0.
